// File: rtl/accum_buff_streamer_pkg.sv
// Shared constants, lane/word types and streamer state for the accumulator readout path.
// Optional peak tracking is enabled by defining PEAK_TRACK_EN.
package hough_pkg;

  localparam int unsigned THETAS           = 180;
  localparam int unsigned RHOS             = 1179;
  localparam int unsigned RHO_RANGE        = 2 * RHOS;
  localparam int unsigned THETA_UNROLL     = 16;
  localparam int unsigned ACCUM_BUFF_WIDTH = 8;
  localparam int unsigned THETA_BITS       = 9;
  localparam int unsigned ADDR_BITS        = 15;
  localparam int unsigned NUM_GROUPS       = (THETAS + THETA_UNROLL - 1) / THETA_UNROLL;
  localparam int unsigned TOTAL_WORDS      = RHO_RANGE * NUM_GROUPS;
  localparam int unsigned WORD_BITS        = THETA_UNROLL * ACCUM_BUFF_WIDTH;
  localparam int unsigned RHO_BITS         = $clog2(RHO_RANGE + 1);
  localparam int unsigned GROUP_BITS       = $clog2(NUM_GROUPS);
  localparam int unsigned LANE_BITS        = $clog2(THETA_UNROLL);

  typedef logic [0:THETA_UNROLL-1][ACCUM_BUFF_WIDTH-1:0] accum_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } streamer_state_e;

  // Peak tracking needs the word's coordinates to travel with it through the skid buffer.
  typedef struct packed {
    accum_word_t            data;
    logic                   last;
`ifdef PEAK_TRACK_EN
    logic [GROUP_BITS-1:0]  grp;
    logic [RHO_BITS-1:0]    rho;
`endif
  } skid_entry_t;

  function automatic logic lane_valid(input logic [GROUP_BITS-1:0] grp, input int unsigned k);
    return (32'(grp) * THETA_UNROLL + k) < THETAS;
  endfunction

  function automatic accum_word_t mask_tail(input accum_word_t w, input logic [GROUP_BITS-1:0] grp);
    accum_word_t m;
    m = w;
    for (int unsigned k = 0; k < THETA_UNROLL; k++) begin
      if (!lane_valid(grp, k)) m[k] = '0;
    end
    return m;
  endfunction

endpackage

// File: rtl/accum_buff_streamer_peak_finder.sv
// Running maximum over the valid lanes of each written word; ties keep the earliest position in stream order.
// Only instantiated when PEAK_TRACK_EN is defined.
module accum_peak_finder
  import hough_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          i_clear,
  input  logic                          i_valid,
  input  accum_word_t                   i_word,
  input  logic [GROUP_BITS-1:0]         i_grp,
  input  logic [RHO_BITS-1:0]           i_rho,
  output logic [ACCUM_BUFF_WIDTH-1:0]   o_peak_value,
  output logic signed [15:0]            o_peak_rho,
  output logic [THETA_BITS-1:0]         o_peak_theta
);

  logic [ACCUM_BUFF_WIDTH-1:0] w_val [THETA_UNROLL];
  logic [LANE_BITS-1:0]        w_idx [THETA_UNROLL];
  logic [ACCUM_BUFF_WIDTH-1:0] r_value;
  logic signed [15:0]          r_rho;
  logic [THETA_BITS-1:0]       r_theta;
  logic signed [15:0]          w_rho;
  logic [THETA_BITS-1:0]       w_theta;

  // In-place pairwise tree: level results overwrite the low half; right wins only when strictly larger.
  always_comb begin
    for (int unsigned k = 0; k < THETA_UNROLL; k++) begin
      w_val[k] = lane_valid(i_grp, k) ? i_word[k] : '0;
      w_idx[k] = LANE_BITS'(k);
    end
    for (int unsigned l = 0; l < LANE_BITS; l++) begin
      for (int unsigned i = 0; i < (THETA_UNROLL >> (l + 1)); i++) begin
        if (w_val[2*i+1] > w_val[2*i]) begin
          w_val[i] = w_val[2*i+1];
          w_idx[i] = w_idx[2*i+1];
        end else begin
          w_val[i] = w_val[2*i];
          w_idx[i] = w_idx[2*i];
        end
      end
    end
  end

  assign w_rho   = 16'(i_rho) - 16'(RHOS);
  assign w_theta = THETA_BITS'(32'(i_grp) * THETA_UNROLL + 32'(w_idx[0]));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_value <= '0;
      r_rho   <= '0;
      r_theta <= '0;
    end else if (i_clear) begin
      r_value <= '0;
      r_rho   <= '0;
      r_theta <= '0;
    end else if (i_valid && (w_val[0] > r_value)) begin
      r_value <= w_val[0];
      r_rho   <= w_rho;
      r_theta <= w_theta;
    end
  end

  assign o_peak_value = r_value;
  assign o_peak_rho   = r_rho;
  assign o_peak_theta = r_theta;

endmodule

// File: rtl/accum_buff_streamer.sv
// Sweeps the accumulator BRAM (group fastest, then rho) into the readout FIFO through a 2-entry skid buffer.
// Define PEAK_TRACK_EN to enable the running peak tracker; otherwise peak outputs are tied to 0.
module accum_buff_streamer
  import hough_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          bram_rd_en,
  output logic [ADDR_BITS-1:0]          bram_rd_addr,
  input  logic [WORD_BITS-1:0]          bram_rd_data,
  input  logic                          out_full,
  output logic                          out_wr_en,
  output logic [WORD_BITS-1:0]          out_din,
  output logic                          out_last,
  output logic [ACCUM_BUFF_WIDTH-1:0]   peak_value,
  output logic signed [15:0]            peak_rho,
  output logic [THETA_BITS-1:0]         peak_theta
);

  localparam logic [GROUP_BITS-1:0] LAST_GRP = GROUP_BITS'(NUM_GROUPS - 1);
  localparam logic [RHO_BITS-1:0]   LAST_RHO = RHO_BITS'(RHO_RANGE - 1);

  streamer_state_e         r_state, w_state_nxt;
  logic [ADDR_BITS-1:0]    r_addr;
  logic [GROUP_BITS-1:0]   r_grp;
  logic [RHO_BITS-1:0]     r_rho;
  logic                    r_if_vld;
  logic                    r_if_last;
  logic [GROUP_BITS-1:0]   r_if_grp;
  skid_entry_t             r_skid0, r_skid1;
  logic [1:0]              r_cnt;
  skid_entry_t             w_ret, w_head;
  logic                    w_start_ok, w_issue, w_last_addr, w_have, w_pop, w_push;

`ifdef PEAK_TRACK_EN
  logic [RHO_BITS-1:0]     r_if_rho;
`endif

  assign w_start_ok  = (r_state == ST_IDLE) && start;
  assign w_last_addr = (r_grp == LAST_GRP) && (r_rho == LAST_RHO);
  // Never let held + in-flight words exceed the two skid slots.
  assign w_issue     = (r_state == ST_RUN) && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && !r_if_vld));

  always_comb begin
    w_ret      = '0;
    w_ret.data = mask_tail(accum_word_t'(bram_rd_data), r_if_grp);
    w_ret.last = r_if_last;
`ifdef PEAK_TRACK_EN
    w_ret.grp  = r_if_grp;
    w_ret.rho  = r_if_rho;
`endif
  end

  assign w_head    = (r_cnt != 2'd0) ? r_skid0 : w_ret;
  assign w_have    = (r_cnt != 2'd0) || r_if_vld;
  assign out_wr_en = w_have && !out_full;
  assign w_pop     = out_wr_en && (r_cnt != 2'd0);
  assign w_push    = r_if_vld && !(out_wr_en && (r_cnt == 2'd0));

  assign out_din      = w_have ? WORD_BITS'(w_head.data) : '0;
  assign out_last     = out_wr_en && w_head.last;
  assign bram_rd_en   = w_issue;
  assign bram_rd_addr = r_addr;
  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
      r_grp  <= '0;
      r_rho  <= '0;
    end else if (w_start_ok) begin
      r_addr <= '0;
      r_grp  <= '0;
      r_rho  <= '0;
    end else if (w_issue) begin
      r_addr <= r_addr + ADDR_BITS'(1);
      if (r_grp == LAST_GRP) begin
        r_grp <= '0;
        r_rho <= r_rho + RHO_BITS'(1);
      end else begin
        r_grp <= r_grp + GROUP_BITS'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_if_vld  <= 1'b0;
      r_if_last <= 1'b0;
      r_if_grp  <= '0;
    end else begin
      r_if_vld  <= w_issue;
      r_if_last <= w_last_addr;
      r_if_grp  <= r_grp;
    end
  end

`ifdef PEAK_TRACK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_if_rho <= '0;
    else        r_if_rho <= r_rho;
  end
`endif

  // Slot 0 is always the head; a simultaneous pop and push shifts slot 1 forward behind the new data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_skid0 <= '0;
      r_skid1 <= '0;
      r_cnt   <= '0;
    end else begin
      unique case ({w_pop, w_push})
        2'b10: begin
          r_skid0 <= r_skid1;
          r_cnt   <= r_cnt - 2'd1;
        end
        2'b01: begin
          if (r_cnt == 2'd0) r_skid0 <= w_ret;
          else               r_skid1 <= w_ret;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_skid0 <= w_ret;
          end else begin
            r_skid0 <= r_skid1;
            r_skid1 <= w_ret;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_issue && w_last_addr) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_wr_en && w_head.last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef PEAK_TRACK_EN
  accum_peak_finder u_peak (
    .clock        (clock),
    .reset        (reset),
    .i_clear      (w_start_ok),
    .i_valid      (out_wr_en),
    .i_word       (w_head.data),
    .i_grp        (w_head.grp),
    .i_rho        (w_head.rho),
    .o_peak_value (peak_value),
    .o_peak_rho   (peak_rho),
    .o_peak_theta (peak_theta)
  );
`else
  assign peak_value = '0;
  assign peak_rho   = '0;
  assign peak_theta = '0;
`endif

endmodule

// File: tb/tb_accum_buff_streamer.sv
// Scoreboard bench for accum_buff_streamer: free-flow, tail mask + mid-sweep reset, backpressure + peak.
`timescale 1ns/1ps
module tb_accum_buff_streamer;
  import hough_pkg::*;

  localparam int NWORDS = 28296;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic out_full = 1'b0;
  logic busy, done, bram_rd_en, out_wr_en, out_last;
  logic [14:0]  bram_rd_addr;
  logic [127:0] bram_rd_data = '0;
  logic [127:0] out_din;
  logic [7:0]   peak_value;
  logic signed [15:0] peak_rho;
  logic [8:0]   peak_theta;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int wr_count = 0;
  int done_count = 0;
  int first_wr_cyc = -1;
  int last_wr_cyc = -1;
  int done_cyc = -1;
  int mem_mode = 0;
  bit bp_en = 1'b0;
  bit bp_held = 1'b0;
  int hold_cnt = 0;
  logic [0:15][7:0] bram_word;

  accum_buff_streamer dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .bram_rd_en   (bram_rd_en),
    .bram_rd_addr (bram_rd_addr),
    .bram_rd_data (bram_rd_data),
    .out_full     (out_full),
    .out_wr_en    (out_wr_en),
    .out_din      (out_din),
    .out_last     (out_last),
    .peak_value   (peak_value),
    .peak_rho     (peak_rho),
    .peak_theta   (peak_theta)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Accumulator contents as seen by the sweep; mode 2 holds two equal peaks of 37.
  function automatic logic [7:0] lane_val(input int mode, input int addr, input int k);
    case (mode)
      0: return 8'((addr + k) % 256);
      1: return 8'hFF;
      default: begin
        if (addr == 1016 * 12 + 8 && k == 0)  return 8'd37;
        if (addr == 1754 * 12 + 3 && k == 12) return 8'd37;
        return 8'((addr + k) % 37);
      end
    endcase
  endfunction

  always @(posedge clock) begin
    if (bram_rd_en) begin
      for (int k = 0; k < 16; k++) bram_word[k] = lane_val(mem_mode, int'(bram_rd_addr), k);
      bram_rd_data <= bram_word;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_word(input string nm, input logic [128:0] act, input logic [128:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push_sweep(input int mode);
    logic [0:15][7:0] w;
    exp_t e;
    int g;
    for (int i = 0; i < NWORDS; i++) begin
      g = i % 12;
      for (int k = 0; k < 16; k++) w[k] = (g * 16 + k < 180) ? lane_val(mode, i, k) : 8'h00;
      e.data = w;
      e.last = (i == NWORDS - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick(1);
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  // Monitor: pops the scoreboard on every FIFO write.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (out_wr_en === 1'b1) begin
        chk("no_write_while_full", int'(out_full), 0);
        chk("sb_has_entry", int'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk_word("word", {out_last, out_din}, {e.last, e.data});
        end
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        wr_count++;
      end
      if (done === 1'b1) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  // Backpressure: random 50% over the first 600 rho rows, plus a 20-cycle hold entering rho row 300.
  initial begin : bp_driver
    forever begin
      @(posedge clock);
      #1;
      if (!bp_en) begin
        out_full = 1'b0;
      end else if (hold_cnt > 0) begin
        out_full = 1'b1;
        hold_cnt--;
      end else if (!bp_held && wr_count == 3600) begin
        bp_held  = 1'b1;
        hold_cnt = 19;
        out_full = 1'b1;
      end else if (wr_count < 7200) begin
        out_full = 1'($urandom_range(0, 1));
      end else begin
        out_full = 1'b0;
      end
    end
  end

  initial begin : main
    bit seen;

    tick(3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(bram_rd_en), 0);
    chk("rst_rd_addr", int'(bram_rd_addr), 0);
    chk("rst_wr_en", int'(out_wr_en), 0);
    chk("rst_last", int'(out_last), 0);
    chk_word("rst_out_din", {1'b0, out_din}, '0);
    chk("rst_peak_value", int'(peak_value), 0);
    chk("rst_peak_rho", int'(peak_rho), 0);
    chk("rst_peak_theta", int'(peak_theta), 0);
    reset = 1'b1;
    tick(2);

    // Free-flow sweep with start pulses while busy and in the done cycle.
    mem_mode = 0;
    push_sweep(0);
    wr_count = 0; done_count = 0; first_wr_cyc = -1;
    pulse_start();
    chk("busy_after_start", int'(busy), 1);
    tick(100);
    pulse_start();
    wait_done(40000, seen);
    chk("done_seen_A", int'(seen), 1);
    if (seen) pulse_start();
    tick(20);
    chk("words_A", wr_count, NWORDS);
    chk("throughput_A", last_wr_cyc - first_wr_cyc, NWORDS - 1);
    chk("done_latency_A", done_cyc - last_wr_cyc, 1);
    chk("done_count_A", done_count, 1);
    chk("sb_empty_A", sb_q.size(), 0);
    chk("idle_busy_A", int'(busy), 0);
    chk("idle_rd_A", int'(bram_rd_en), 0);

    // All-0xFF sweep aborted by reset after 5000 words.
    mem_mode = 1;
    push_sweep(1);
    wr_count = 0; done_count = 0;
    pulse_start();
    for (int i = 0; i < 10000 && wr_count < 5000; i++) tick(1);
    chk("reached_5000", int'(wr_count >= 5000), 1);
    reset = 1'b0;
    sb_q.delete();
    tick(3);
    chk("abort_busy", int'(busy), 0);
    chk("abort_wr_en", int'(out_wr_en), 0);
    chk("abort_rd_en", int'(bram_rd_en), 0);
    chk("abort_no_done", done_count, 0);
    reset = 1'b1;
    tick(2);

    // Restarted sweep under backpressure, data carrying the peak pattern.
    mem_mode = 2;
    push_sweep(2);
    wr_count = 0; done_count = 0; bp_held = 1'b0; bp_en = 1'b1;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bram_rd_en === 1'b1) begin
        seen = 1'b1;
        chk("restart_addr0", int'(bram_rd_addr), 0);
      end else begin
        tick(1);
      end
    end
    chk("restart_read_seen", int'(seen), 1);
    wait_done(60000, seen);
    chk("done_seen_C", int'(seen), 1);
    tick(5);
    bp_en = 1'b0;
    chk("words_C", wr_count, NWORDS);
    chk("done_count_C", done_count, 1);
    chk("sb_empty_C", sb_q.size(), 0);
    chk("hold_applied_C", int'(bp_held), 1);
`ifdef PEAK_TRACK_EN
    chk("peak_value", int'(peak_value), 37);
    chk("peak_rho", int'(peak_rho), -163);
    chk("peak_theta", int'(peak_theta), 128);
`else
    chk("peak_value_off", int'(peak_value), 0);
    chk("peak_rho_off", int'(peak_rho), 0);
    chk("peak_theta_off", int'(peak_theta), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
